simple_dual_port_ram: RTL and testbench

- Simple dual-port synchronous RAM: one write port, one read port, one shared clock.
- Used by the switch output buffer to capture accepted result bytes per output port; a host drains them over the register interface.
- One instance per output port.
- Write and read addresses are independent counters owned by the instantiating block.

---
 rtl/simple_dual_port_ram_if.sv | 30 +++
 rtl/simple_dual_port_ram.sv | 57 +++++
 tb/tb_simple_dual_port_ram.sv | 130 +++++++++++++
 3 files changed

// File: rtl/simple_dual_port_ram_if.sv
// ============================================================================
// Module   : simple_dual_port_ram_if
// Purpose  : Write/read port bundle for the simple dual-port RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface simple_dual_port_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] wraddress;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] rdaddress;
    logic                  rden;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        output data, wraddress, wren, rdaddress, rden,
        input  q
    );

    modport slave (
        input  data, wraddress, wren, rdaddress, rden,
        output q
    );
endinterface

`default_nettype wire

// File: rtl/simple_dual_port_ram.sv
// ============================================================================
// Module   : simple_dual_port_ram
// Purpose  : One-write/one-read synchronous RAM with registered read data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module simple_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 16384
) (
    input  wire logic             clock,
    input  wire logic             reset,
    simple_dual_port_ram_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] C_DEPTH = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    assign w_wr_in_range = ({1'b0, bus.wraddress} < C_DEPTH);
    assign w_rd_in_range = ({1'b0, bus.rdaddress} < C_DEPTH);

    // Reset blocks the write so a reset cycle never disturbs stored data.
    always_ff @(posedge clock) begin
        if (!reset && bus.wren && w_wr_in_range) begin
            mem[bus.wraddress] <= bus.data;
        end
    end

    // Array is sampled before this edge's write lands: read-during-write gives old data.
    always_comb begin
        rd_data_d = rd_data_q;
        if (bus.rden) begin
            rd_data_d = w_rd_in_range ? mem[bus.rdaddress] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.q = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_simple_dual_port_ram.sv
// ============================================================================
// Module   : tb_simple_dual_port_ram
// Purpose  : Scoreboard bench for simple_dual_port_ram.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_simple_dual_port_ram;

    localparam int C_DW    = 8;
    localparam int C_AW    = 14;
    localparam int C_DEPTH = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;

    simple_dual_port_ram_if #(.DATA_WIDTH(C_DW), .ADDR_WIDTH(C_AW)) bus ();

    simple_dual_port_ram #(
        .DATA_WIDTH (C_DW),
        .ADDR_WIDTH (C_AW),
        .DEPTH      (C_DEPTH)
    ) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned      n_total = 0;
    int unsigned      n_bad   = 0;
    logic [C_DW-1:0]  exp_q [$];
    logic [C_DW-1:0]  mem_m [int];
    logic [C_DW-1:0]  model_q = '0;

    task automatic chk(input string tag, input logic [C_DW-1:0] obs, input logic [C_DW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h want 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, push the expected q for this edge, then pop and compare after it.
    task automatic step(input logic r, input logic w, input logic [C_AW-1:0] wa,
                        input logic [C_DW-1:0] d, input logic rd, input logic [C_AW-1:0] ra);
        logic [C_DW-1:0] e;
        logic [C_DW-1:0] got;
        rst           = r;
        bus.wren      = w;
        bus.wraddress = wa;
        bus.data      = d;
        bus.rden      = rd;
        bus.rdaddress = ra;
        e = model_q;
        if (r) begin
            e = '0;
        end else begin
            if (rd) e = (int'(ra) < C_DEPTH && mem_m.exists(int'(ra))) ? mem_m[int'(ra)] : '0;
            if (w && int'(wa) < C_DEPTH) mem_m[int'(wa)] = d;
        end
        model_q = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = bus.q;
        if (exp_q.size() == 0) begin
            chk("sb_empty", got, ~got);
        end else begin
            chk("sb", got, exp_q.pop_front());
        end
    endtask

    initial begin
        bus.wren      = 1'b0;
        bus.rden      = 1'b0;
        bus.data      = '0;
        bus.wraddress = '0;
        bus.rdaddress = '0;

        // Reset with a read pending
        step(1, 0, 0, 8'h00, 1, 0);           chk("rst_q", bus.q, 8'h00);
        step(0, 1, 0, 8'h06, 0, 0);
        step(0, 0, 0, 8'h00, 1, 0);           chk("rd_a0", bus.q, 8'h06);

        // Consecutive writes then streaming reads
        for (int i = 1; i <= 3; i++) step(0, 1, C_AW'(i), C_DW'(i), 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 8'h00, 1, C_AW'(i));
            chk("stream", bus.q, C_DW'(i));
        end

        // Read-during-write on the same address
        step(0, 1, 5, 8'hAA, 0, 0);
        step(0, 1, 5, 8'h55, 1, 5);           chk("rdw_old", bus.q, 8'hAA);
        step(0, 0, 0, 8'h00, 1, 5);           chk("rdw_new", bus.q, 8'h55);

        // Hold when rden is low
        step(0, 1, 7, 8'h3F, 0, 0);
        step(0, 0, 0, 8'h00, 1, 7);           chk("rd_a7", bus.q, 8'h3F);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'h00, 0, C_AW'(20 + i));
            chk("hold", bus.q, 8'h3F);
        end

        // Top address and never-written address
        step(0, 1, 14'h3FFF, 8'h4F, 0, 0);
        step(0, 0, 0, 8'h00, 1, 14'h3FFF);    chk("rd_top", bus.q, 8'h4F);
        step(0, 0, 0, 8'h00, 1, 10);          chk("rd_unwr", bus.q, 8'h00);

        // Reset blocks a write and retains contents
        step(0, 1, 9, 8'h5B, 1, 7);           chk("pre_rst", bus.q, 8'h3F);
        step(1, 1, 9, 8'hFF, 1, 9);           chk("rst_mid", bus.q, 8'h00);
        step(0, 0, 0, 8'h00, 0, 9);           chk("post_rst", bus.q, 8'h00);
        step(0, 0, 0, 8'h00, 1, 9);           chk("retain", bus.q, 8'h5B);

        // Random traffic over a small address window
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), C_AW'($urandom_range(0, 15)),
                 C_DW'($urandom), 1'($urandom), C_AW'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
